hcod_granule_buffer: RTL and testbench

Collects signed (x, y) sample pairs from the Huffman table decoders, one pair per `pair_valid` pulse. Writes them into a 576-sample granule store and zero-fills every pair position beyond `big_values`. It then streams the granule in frequency-line order to the requantizer over a valid/ready interface. It sits directly downstream of the per-table Huffman decode modules (e.g. HT_30) and upstream of requantization; count1-region quads are out of scope for this revision and read back as zero.

---
 rtl/mp3_pkg.sv | 7 +
 rtl/pair_ram.sv | 24 ++
 rtl/hcod_granule_buffer.sv | 112 +++++++++++
 tb/tb_hcod_granule_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// mp3_pkg: shared granule constants, sample type and granule buffer state encoding
package mp3_pkg;
    localparam int GRANULE_SAMPLES = 576;
    localparam int GRANULE_PAIRS = 288;
    typedef logic signed [15:0] sample_t;
    typedef enum logic [1:0] {IDLE, FILL, ZERO, DRAIN} gbuf_state_t;
endpackage

// File: rtl/pair_ram.sv
// pair_ram: single-port synchronous RAM, write-first, one-cycle read, no reset
module pair_ram #(
    parameter int DEPTH = 288,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/hcod_granule_buffer.sv
// hcod_granule_buffer: collects Huffman (x, y) pairs, zero-fills past big_values, streams 576 samples
module hcod_granule_buffer
    import mp3_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int PAIRS = GRANULE_PAIRS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [8:0]                 big_values,
    output logic                       busy,
    input  logic                       pair_valid,
    input  logic signed [SAMPLE_W-1:0] x_val,
    input  logic signed [SAMPLE_W-1:0] y_val,
    output logic                       bv_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic [9:0]                 out_index,
    output logic                       out_last,
    output logic                       err
);
    gbuf_state_t state, state_nxt;
    logic [8:0] bv, bv_in, k;
    logic word_rdy, fill_last, zero_last, x_take, y_take, rd_en, drain_done;
    logic ram_we, ram_en;
    logic [2*SAMPLE_W-1:0] ram_wdata, ram_rdata;

    pair_ram #(.DEPTH(PAIRS), .WIDTH(2*SAMPLE_W)) u_ram (
        .clk(clk),
        .en(ram_en),
        .we(ram_we),
        .addr(k),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // k addresses the RAM in every state; in DRAIN it is the next word to fetch
    always_comb begin
        bv_in = big_values > 9'(PAIRS) ? 9'(PAIRS) : big_values;
        fill_last = state == FILL && pair_valid && k == bv - 9'd1;
        zero_last = state == ZERO && k == 9'(PAIRS-1);
        y_take = state == DRAIN && out_valid && out_ready && !out_index[0];
        x_take = state == DRAIN && word_rdy && (!out_valid || (out_ready && out_index[0]));
        rd_en = state == DRAIN && ((k == 9'd0 && !word_rdy && !out_valid) || (y_take && k != 9'(PAIRS)));
        drain_done = state == DRAIN && out_valid && out_ready && out_last;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = bv_in == 9'd0 ? ZERO : FILL;
            FILL: if (fill_last) state_nxt = bv == 9'(PAIRS) ? DRAIN : ZERO;
            ZERO: if (zero_last) state_nxt = DRAIN;
            DRAIN: if (drain_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
        ram_we = (state == FILL && pair_valid) || state == ZERO;
        ram_en = ram_we || rd_en;
        ram_wdata = state == FILL ? {x_val, y_val} : '0;
    end

    // the y half stays in ram_rdata while x is presented, so the next fetch issues as x is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            bv <= '0;
            k <= '0;
            err <= 1'b0;
            bv_done <= 1'b0;
            word_rdy <= 1'b0;
            out_valid <= 1'b0;
            out_sample <= '0;
            out_index <= '0;
            out_last <= 1'b0;
        end else begin
            bv_done <= (state == IDLE && start && bv_in == 9'd0) || fill_last;
            if (state == IDLE && start) begin
                bv <= bv_in;
                k <= '0;
                err <= big_values > 9'(PAIRS);
            end else begin
                if (pair_valid && state != FILL) err <= 1'b1;
                if (ram_en) k <= (fill_last && bv == 9'(PAIRS)) || zero_last ? 9'd0 : k + 9'd1;
            end
            if (rd_en) word_rdy <= 1'b1;
            else if (x_take) word_rdy <= 1'b0;
            if (x_take) begin
                out_valid <= 1'b1;
                out_sample <= ram_rdata[2*SAMPLE_W-1:SAMPLE_W];
                out_index <= out_valid ? out_index + 10'd1 : 10'd0;
                out_last <= 1'b0;
            end else if (y_take) begin
                out_sample <= ram_rdata[SAMPLE_W-1:0];
                out_index <= out_index + 10'd1;
                out_last <= out_index == 10'(2*PAIRS-2);
            end else if (drain_done) begin
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hcod_granule_buffer.sv
// tb_hcod_granule_buffer: scoreboard bench for the granule buffer fill / zero-fill / drain flow
module tb_hcod_granule_buffer;
    import mp3_pkg::*;

    typedef struct {
        int s;
        int idx;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [8:0] big_values = '0;
    logic busy;
    logic pair_valid = 1'b0;
    sample_t x_val = '0;
    sample_t y_val = '0;
    logic bv_done;
    logic out_valid;
    logic out_ready = 1'b1;
    sample_t out_sample;
    logic [9:0] out_index;
    logic out_last;
    logic err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bv_done_cnt, bv_done_cyc, first_valid_cyc, first_fire, last_fire, nout;
    bit seen_valid;
    bit rand_ready = 1'b0;
    int px[300];
    int py[300];
    exp_t exp_q[$];

    hcod_granule_buffer #(.SAMPLE_W(16), .PAIRS(288)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .big_values(big_values),
        .busy(busy),
        .pair_valid(pair_valid),
        .x_val(x_val),
        .y_val(y_val),
        .bv_done(bv_done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sample(out_sample),
        .out_index(out_index),
        .out_last(out_last),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (bv_done) begin
            bv_done_cnt++;
            bv_done_cyc = cyc;
        end
        if (out_valid && !seen_valid) begin
            seen_valid = 1'b1;
            first_valid_cyc = cyc;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", int'(out_index), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sample", int'(out_sample), e.s);
                check("index", int'(out_index), e.idx);
                check("last", int'(out_last), e.last);
            end
            nout++;
            if (nout == 1) first_fire = cyc;
            last_fire = cyc;
        end
    end

    task automatic run_granule(input int bv, input int np, input bit rr, input int exp_err);
        int eb, t;
        eb = bv > 288 ? 288 : bv;
        for (int i = 0; i < 288; i++) begin
            int xs, ys;
            xs = (i < eb && i < np) ? px[i] : 0;
            ys = (i < eb && i < np) ? py[i] : 0;
            exp_q.push_back('{xs, 2 * i, 0});
            exp_q.push_back('{ys, 2 * i + 1, i == 287 ? 1 : 0});
        end
        bv_done_cnt = 0;
        nout = 0;
        seen_valid = 1'b0;
        rand_ready = rr;
        @(posedge clk);
        #1 start = 1'b1;
        big_values = 9'(bv);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_rise", int'(busy), 1);
        if (eb == 0) check("bv_done_zero", int'(bv_done), 1);
        for (int i = 0; i < np; i++) begin
            x_val = sample_t'(px[i]);
            y_val = sample_t'(py[i]);
            pair_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        pair_valid = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", int'(t < 4000), 1);
        check("err", int'(err), exp_err);
        check("bv_done_pulses", bv_done_cnt, 1);
        check("sample_count", nout, 576);
        check("first_valid_delay", first_valid_cyc - bv_done_cyc, 288 - eb + 2);
        if (!rr) check("throughput", last_fire - first_fire, 575);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_bv_done", int'(bv_done), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_err", int'(err), 0);

        px[0] = 1; py[0] = -1;
        px[1] = 15; py[1] = 0;
        px[2] = -2062; py[2] = 7;
        run_granule(3, 3, 1'b0, 0);

        run_granule(0, 0, 1'b0, 0);

        for (int i = 0; i < 288; i++) begin
            px[i] = i;
            py[i] = -i;
        end
        run_granule(288, 288, 1'b0, 0);

        for (int i = 0; i < 300; i++) begin
            px[i] = i + 1000;
            py[i] = -3 * i;
        end
        run_granule(300, 295, 1'b1, 1);

        for (int i = 0; i < 50; i++) begin
            px[i] = int'($urandom_range(0, 65535)) - 32768;
            py[i] = int'($urandom_range(0, 65535)) - 32768;
        end
        run_granule(50, 50, 1'b1, 0);

        // abort a granule mid-fill, then confirm nothing stale leaks into the next one
        rand_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        big_values = 9'd200;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            x_val = sample_t'(i + 77);
            y_val = sample_t'(-i - 77);
            pair_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        pair_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_err", int'(err), 0);
        @(posedge clk);
        #1 pair_valid = 1'b1;
        @(posedge clk);
        #1 pair_valid = 1'b0;
        @(negedge clk);
        check("idle_pair_err", int'(err), 1);
        check("idle_pair_busy", int'(busy), 0);

        px[0] = 5; py[0] = 5;
        px[1] = 6; py[1] = 6;
        run_granule(2, 2, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
